alu_share_arbiter: RTL

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared 16-bit add/subtract/compare datapath.
// Optional feature macro: LT_OVF_CORRECT_EN -- when defined, LT is a true signed
// compare (sign of x-y corrected for overflow); when undefined, LT is bit 15 of x-y.
module alu_share_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_x,
    input  logic [15:0] req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_x,
    input  logic [15:0] req1_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_flag
);

    localparam int unsigned W = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           accept;
    logic           grant_id;
    logic           last_q;
    logic [1:0]     op_q;
    logic [W-1:0]   x_q;
    logic [W-1:0]   y_q;
    logic           id_q;

    logic [W-1:0]   alu_b;
    logic           alu_cin;
    logic [W:0]     alu_sum;
    logic [W-1:0]   alu_diff;
    logic           alu_ovf;
    logic           alu_lt;
    logic [W-1:0]   alu_result;
    logic           alu_flag;

    // Grant selection: single valid wins; a tie goes to requester 0 in fixed mode,
    // otherwise to the requester that was not granted last.
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = PRIO_FIXED ? 1'b0 : ~last_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and accept handshake; ready is gated by rst_n so it drops immediately in reset.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shared adder: ADD uses x+y, SUB and LT use x+~y+1.
    always_comb begin
        alu_b    = (op_q == OP_ADD) ? y_q : ~y_q;
        alu_cin  = (op_q != OP_ADD);
        alu_sum  = {1'b0, x_q} + {1'b0, alu_b} + (W+1)'(alu_cin);
        alu_diff = alu_sum[W-1:0];
        alu_ovf  = (x_q[W-1] ^ y_q[W-1]) & (alu_diff[W-1] ^ x_q[W-1]);
`ifdef LT_OVF_CORRECT_EN
        alu_lt   = alu_diff[W-1] ^ alu_ovf;
`else
        alu_lt   = alu_diff[W-1];
`endif
        alu_result = '0;
        alu_flag   = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                alu_result = alu_sum[W-1:0];
                alu_flag   = alu_sum[W];
            end
            OP_LT: begin
                alu_result = alu_lt ? {W{1'b1}} : '0;
                alu_flag   = alu_lt;
            end
            default: begin
                alu_result = '0;
                alu_flag   = 1'b0;
            end
        endcase
    end

    // Operand capture on accept, result register in EXEC, response hold until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= 2'b00;
            x_q        <= '0;
            y_q        <= '0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flag   <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= grant_id ? req1_op : req0_op;
                x_q    <= grant_id ? req1_x  : req0_x;
                y_q    <= grant_id ? req1_y  : req0_y;
                id_q   <= grant_id;
                last_q <= grant_id;
            end
            if (state_q == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= id_q;
                rsp_result <= alu_result;
                rsp_flag   <= alu_flag;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule
